pmp_check_arbiter: RTL and testbench

PMP_CHECK_ARBITER -- requirements
Module: pmp_check_arbiter

---
 rtl/pmp_check_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_pmp_check_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pmp_check_arbiter.sv
// Two-requester front end sharing one PMP checker: round-robin grant, a
// one-entry registered response per check, and a saturating deny counter.
`timescale 1ns/1ps

package riscv;
    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [2:0] {
        ACCESS_NONE  = 3'b000,
        ACCESS_READ  = 3'b001,
        ACCESS_WRITE = 3'b010,
        ACCESS_EXEC  = 3'b100
    } pmp_access_t;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_addr_mode_t;

    typedef struct packed {
        logic x;
        logic w;
        logic r;
    } pmpcfg_access_t;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmpcfg_access_t access_type;
    } pmpcfg_t;
endpackage

module pmp #(
    parameter int unsigned WIDTH      = 34,
    parameter int unsigned PMP_LEN    = 32,
    parameter int unsigned NR_ENTRIES = 4
) (
    input  logic [WIDTH-1:0]                    addr,
    input  riscv::pmp_access_t                  access,
    input  riscv::priv_lvl_t                    priv_lvl,
    input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]  conf_addr,
    input  riscv::pmpcfg_t [NR_ENTRIES-1:0]     conf,
    output logic                                allow
);
    localparam int unsigned LW = (WIDTH > PMP_LEN + 2) ? WIDTH : PMP_LEN + 2;

    logic [LW-1:0]   a, base, lo, napot_mask;
    logic            match, hit;
    riscv::pmpcfg_t  hit_cfg;
    logic [2:0]      acc;
    logic [1:0]      unused_rsvd;

    assign unused_rsvd = hit_cfg.reserved;

    always_comb begin
        a          = LW'(addr);
        acc        = access;
        lo         = '0;
        base       = '0;
        napot_mask = '0;
        match      = 1'b0;
        hit        = 1'b0;
        hit_cfg    = '0;
        allow      = 1'b0;
        // Lowest-numbered matching entry wins; TOR uses the previous entry as its bottom.
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            base       = LW'({conf_addr[i], 2'b00});
            napot_mask = LW'({conf_addr[i] ^ (conf_addr[i] + PMP_LEN'(1)), 2'b11});
            case (conf[i].addr_mode)
                riscv::TOR:   match = (a >= lo) && (a < base);
                riscv::NA4:   match = (a[LW-1:2] == base[LW-1:2]);
                riscv::NAPOT: match = ((a ^ base) & ~napot_mask) == '0;
                default:      match = 1'b0;
            endcase
            if (match && !hit) begin
                hit     = 1'b1;
                hit_cfg = conf[i];
            end
            lo = base;
        end
        if (hit) begin
            if (priv_lvl == riscv::PRIV_LVL_M && !hit_cfg.locked) allow = 1'b1;
            else allow = ((acc & hit_cfg.access_type) == acc);
        end else begin
            allow = (priv_lvl == riscv::PRIV_LVL_M);
        end
    end
endmodule

module pmp_check_arbiter #(
    parameter int unsigned WIDTH      = 34,
    parameter int unsigned PMP_LEN    = 32,
    parameter int unsigned NR_ENTRIES = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [1:0]                          req_valid_i,
    output logic [1:0]                          req_ready_o,
    input  logic [1:0][WIDTH-1:0]               req_addr_i,
    input  riscv::pmp_access_t [1:0]            req_access_i,
    input  riscv::priv_lvl_t                    priv_lvl_i,
    input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]  conf_addr_i,
    input  riscv::pmpcfg_t [NR_ENTRIES-1:0]     conf_i,
    input  logic                                flush_i,
    output logic [1:0]                          rsp_valid_o,
    input  logic [1:0]                          rsp_ready_i,
    output logic                                rsp_allow_o,
    output logic [15:0]                         deny_cnt_o
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t      state_q, state_d;
    logic        held_id_q, held_id_d;
    logic        held_allow_q, held_allow_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        winner, check_allow, consume, can_accept, accept;

    assign winner = (&req_valid_i) ? ~last_q : req_valid_i[1];

    pmp #(
        .WIDTH      (WIDTH),
        .PMP_LEN    (PMP_LEN),
        .NR_ENTRIES (NR_ENTRIES)
    ) i_pmp (
        .addr      (req_addr_i[winner]),
        .access    (req_access_i[winner]),
        .priv_lvl  (priv_lvl_i),
        .conf_addr (conf_addr_i),
        .conf      (conf_i),
        .allow     (check_allow)
    );

    always_comb begin
        state_d      = state_q;
        held_id_d    = held_id_q;
        held_allow_d = held_allow_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        req_ready_o  = '0;
        rsp_valid_o  = '0;
        consume      = (state_q == RESP) && rsp_ready_i[held_id_q];
        can_accept   = rst_ni && !flush_i && (state_q == IDLE || consume);
        accept       = can_accept && req_valid_i[winner];
        req_ready_o[winner] = accept;
        if (state_q == RESP) rsp_valid_o[held_id_q] = 1'b1;
        // A flushed response is dropped even if its consumer is ready in the same cycle.
        if (consume && !flush_i && !held_allow_q && cnt_q != '1) cnt_d = cnt_q + 16'd1;
        if (flush_i) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d      = RESP;
            held_id_d    = winner;
            held_allow_d = check_allow;
            last_d       = winner;
        end else if (consume) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            held_id_q    <= 1'b0;
            held_allow_q <= 1'b0;
            last_q       <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            held_id_q    <= held_id_d;
            held_allow_q <= held_allow_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rsp_allow_o = held_allow_q;
    assign deny_cnt_o  = cnt_q;
endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Directed bench for pmp_check_arbiter: driver pushes expected responses into a
// queue, a negedge monitor pops and compares them when a response is consumed.
`timescale 1ns/1ps

module tb_pmp_check_arbiter;
    localparam int unsigned WIDTH = 34, PMP_LEN = 32, NR_ENTRIES = 4;

    logic                               clk = 1'b0;
    logic                               rst_n;
    logic [1:0]                         req_valid, req_ready;
    logic [1:0][WIDTH-1:0]              req_addr;
    riscv::pmp_access_t [1:0]           req_access;
    riscv::priv_lvl_t                   priv_lvl;
    logic [NR_ENTRIES-1:0][PMP_LEN-1:0] conf_addr;
    riscv::pmpcfg_t [NR_ENTRIES-1:0]    conf;
    logic                               flush;
    logic [1:0]                         rsp_valid, rsp_ready;
    logic                               rsp_allow;
    logic [15:0]                        deny_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  exp_q[$];   // {id, allow}
    logic        hv, hid, ha;
    logic [15:0] cnt_exp;
    logic        nxt;

    always #5 clk = ~clk;

    pmp_check_arbiter #(.WIDTH(WIDTH), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR_ENTRIES)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_access_i (req_access),
        .priv_lvl_i   (priv_lvl),
        .conf_addr_i  (conf_addr),
        .conf_i       (conf),
        .flush_i      (flush),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_allow_o  (rsp_allow),
        .deny_cnt_o   (deny_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic riscv::pmpcfg_t mk_cfg(input riscv::pmp_addr_mode_t mode, input logic [2:0] xwr);
        riscv::pmpcfg_t c;
        c = '0;
        c.addr_mode   = mode;
        c.access_type = xwr;
        return c;
    endfunction

    // One clock cycle: check outputs at negedge against the expected state, then
    // advance the expected state for the coming rising edge. er is the hand-computed
    // expected req_ready, ea the expected result of the check accepted this cycle.
    task automatic cycle(input logic [1:0] er, input logic ea);
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(er));
        check("rsp_valid", 32'(rsp_valid), hv ? (hid ? 32'd2 : 32'd1) : 32'd0);
        if (hv) check("rsp_allow", 32'(rsp_allow), 32'(ha));
        check("deny_cnt", 32'(deny_cnt), 32'(cnt_exp));
        if (!rst_n) begin
            hv = 1'b0;
            cnt_exp = '0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else if (flush) begin
            if (hv && exp_q.size() != 0) void'(exp_q.pop_front());
            hv = 1'b0;
        end else begin
            if (hv && rsp_ready[hid]) begin
                if (!ha && cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
                hv = 1'b0;
            end
            if (er != 2'b00) begin
                hv  = 1'b1;
                hid = er[1];
                ha  = ea;
                exp_q.push_back({hid, ha});
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a response is delivered when the pending requester's ready is high.
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst_n && !flush && (rsp_valid & rsp_ready) != 2'b00) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got valid %b with no expected response", rsp_valid);
            end else begin
                e = exp_q.pop_front();
                check("mon_id", 32'(rsp_valid[1]), 32'(e[1]));
                check("mon_allow", 32'(rsp_allow), 32'(e[0]));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hv = 1'b0; hid = 1'b0; ha = 1'b0; cnt_exp = '0; nxt = 1'b0;
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        rsp_ready  = 2'b00;
        flush      = 1'b0;
        priv_lvl   = riscv::PRIV_LVL_U;
        req_addr[0] = 34'h19BA;
        req_addr[1] = 34'h19BA;
        req_access[0] = riscv::ACCESS_READ;
        req_access[1] = riscv::ACCESS_READ;
        conf_addr  = '0;
        conf       = '0;
        conf_addr[2] = 32'h65F;                 // NAPOT 0x1900, 256 bytes
        conf[2]      = mk_cfg(riscv::NAPOT, 3'b111);

        // Reset: ready held low even with both requesters valid
        cycle(2'b00, 1'b0);
        cycle(2'b00, 1'b0);
        rst_n = 1'b1;
        check("reset_allow", 32'(rsp_allow), 32'd0);

        // Single allowed read from requester 0, latency 1
        req_valid = 2'b01;
        cycle(2'b01, 1'b1);
        req_valid = 2'b00; rsp_ready = 2'b01;
        cycle(2'b00, 1'b0);
        rsp_ready = 2'b00;
        cycle(2'b00, 1'b0);

        // Denying entry 1 overlaps entry 2; both requesters stream, grants alternate
        conf_addr[1] = 32'h66D;                 // NAPOT 0x19B0, 16 bytes
        conf[1]      = mk_cfg(riscv::NAPOT, 3'b000);
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int i = 0; i < 6; i++) cycle((i % 2 == 0) ? 2'b10 : 2'b01, 1'b0);
        req_valid = 2'b00;
        cycle(2'b00, 1'b0);

        // Held response stays stable while configuration changes
        req_valid = 2'b01; rsp_ready = 2'b00;
        cycle(2'b01, 1'b0);
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            conf[1] = (i % 2 == 0) ? mk_cfg(riscv::NAPOT, 3'b111) : mk_cfg(riscv::OFF, 3'b000);
            cycle(2'b00, 1'b0);
        end
        rsp_ready = 2'b10;                      // other requester's ready is ignored
        cycle(2'b00, 1'b0);
        conf[1] = mk_cfg(riscv::NAPOT, 3'b000);
        req_valid = 2'b00; rsp_ready = 2'b01;
        cycle(2'b00, 1'b0);

        // Flush discards a held deny without counting and blocks acceptance
        req_valid = 2'b10; rsp_ready = 2'b00;
        cycle(2'b10, 1'b0);
        flush = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        cycle(2'b00, 1'b0);
        flush = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        cycle(2'b00, 1'b0);

        // Stream denies up to 0xFFFE, then saturate; requester 1 granted last
        req_valid = 2'b11; rsp_ready = 2'b11; nxt = 1'b0;
        while (cnt_exp != 16'hFFFE) begin
            cycle(nxt ? 2'b10 : 2'b01, 1'b0);
            nxt = !nxt;
        end
        for (int i = 0; i < 2; i++) begin
            cycle(nxt ? 2'b10 : 2'b01, 1'b0);
            nxt = !nxt;
        end
        req_valid = 2'b00;
        cycle(2'b00, 1'b0);
        cycle(2'b00, 1'b0);
        check("deny_sat", 32'(deny_cnt), 32'hFFFF);
        req_valid = 2'b01;
        cycle(2'b01, 1'b0);
        req_valid = 2'b00;
        cycle(2'b00, 1'b0);
        cycle(2'b00, 1'b0);

        // Reset with a held response: discarded, pointer back to requester 0
        req_valid = 2'b01; rsp_ready = 2'b00;
        cycle(2'b01, 1'b0);
        rst_n = 1'b0; req_valid = 2'b11;
        cycle(2'b00, 1'b0);
        rst_n = 1'b1;
        check("post_reset_valid", 32'(rsp_valid), 32'd0);
        check("post_reset_allow", 32'(rsp_allow), 32'd0);
        check("post_reset_cnt", 32'(deny_cnt), 32'd0);
        cycle(2'b01, 1'b0);
        req_valid = 2'b00; rsp_ready = 2'b11;
        cycle(2'b00, 1'b0);
        rsp_ready = 2'b00;
        cycle(2'b00, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
